// File: rtl/serial_adder_8b.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_8b
// Brief    : Bit-serial unsigned adder, LSB first, one full adder + carry FF.
// Revision : 1.0
// ============================================================================
module serial_adder_8b #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             reset_n,
    input  logic             clk,
    input  logic             start,
    output logic [WIDTH-1:0] sum,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;

    logic               w_sum_bit;
    logic               w_carry_bit;

    assign w_sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign w_carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = data1;
                    b_d     = data2;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // One extra cycle after the last shift publishes the finished word.
                if (cnt_q == CNT_W'(WIDTH)) begin
                    sum_d   = res_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    carry_d = w_carry_bit;
                    a_d     = a_q >> 1;
                    b_d     = b_q >> 1;
                    res_d   = {w_sum_bit, res_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    done_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum  = sum_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_8b.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_8b
// Brief    : Directed self-checking bench for serial_adder_8b.
// Revision : 1.0
// ============================================================================
module tb_serial_adder_8b;

    logic [7:0] data1;
    logic [7:0] data2;
    logic       reset_n;
    logic       clk;
    logic       start;
    logic [7:0] sum;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic [7:0] last_sum;

    serial_adder_8b #(.WIDTH(8)) dut (
        .data1   (data1),
        .data2   (data2),
        .reset_n (reset_n),
        .clk     (clk),
        .start   (start),
        .sum     (sum),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one add; start stays high for `hold` edges (hold<0: never dropped).
    // Operands are scrambled right after load, and the old sum must stay visible mid-add.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                         output int latency);
        data1 = a;
        data2 = b;
        start = 1'b1;
        @(posedge clk); #1;
        latency = 0;
        if (hold >= 0 && latency + 1 >= hold) start = 1'b0;
        data1 = 8'($urandom);
        data2 = 8'($urandom);
        while (done !== 1'b1 && latency < 30) begin
            @(posedge clk); #1;
            latency++;
            if (hold >= 0 && latency + 1 >= hold) start = 1'b0;
            if (latency == 4) chk("sum_held_mid_add", sum, last_sum);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        data1   = 8'h00;
        data2   = 8'h00;
        last_sum = 8'h00;

        #100;
        chk("reset_sum", sum, 8'h00);
        chk("reset_done", done, 1'b0);
        #50 reset_n = 1'b1;
        #50;

        // 3 + 7, start held 4 cycles
        do_op(8'h03, 8'h07, 4, lat);
        chk("t1_latency", lat, 9);
        chk("t1_sum", sum, 8'h0A);
        chk("t1_done", done, 1'b1);
        last_sum = 8'h0A;
        @(posedge clk); #1;
        chk("t1_done_fall", done, 1'b0);
        chk("t1_sum_kept", sum, 8'h0A);

        do_op(8'hFF, 8'h01, 1, lat);
        chk("t2_latency", lat, 9);
        chk("t2_sum_wrap", sum, 8'h00);
        chk("t2_done", done, 1'b1);
        last_sum = 8'h00;
        @(posedge clk); #1;

        do_op(8'hA5, 8'h5A, 1, lat);
        chk("t3a_sum", sum, 8'hFF);
        last_sum = 8'hFF;
        @(posedge clk); #1;
        do_op(8'h80, 8'h80, 1, lat);
        chk("t3b_sum", sum, 8'h00);
        last_sum = 8'h00;
        @(posedge clk); #1;

        // start held high through DONE must not retrigger
        do_op(8'h11, 8'h22, -1, lat);
        chk("t4_first_sum", sum, 8'h33);
        data1 = 8'h40;
        data2 = 8'h40;
        repeat (12) @(posedge clk);
        #1;
        chk("t4_done_held", done, 1'b1);
        chk("t4_sum_stable", sum, 8'h33);
        start = 1'b0;
        @(posedge clk); #1;
        chk("t4_done_drop", done, 1'b0);
        last_sum = 8'h33;
        do_op(8'h12, 8'h34, 1, lat);
        chk("t4_second_sum", sum, 8'h46);
        chk("t4_second_lat", lat, 9);
        last_sum = 8'h46;
        @(posedge clk); #1;

        // capture at load: bits of a different operand pair would change the result
        do_op(8'h6C, 8'h39, 1, lat);
        chk("t5_captured_sum", sum, 8'hA5);
        last_sum = 8'hA5;
        @(posedge clk); #1;

        // asynchronous reset in the middle of an add
        data1 = 8'h55;
        data2 = 8'h0F;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_sum", sum, 8'h00);
        chk("t6_async_done", done, 1'b0);
        #12 reset_n = 1'b1;
        @(posedge clk); #1;
        last_sum = 8'h00;
        do_op(8'h0F, 8'h01, 1, lat);
        chk("t6_after_sum", sum, 8'h10);
        chk("t6_after_lat", lat, 9);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
